exhaustive_sweeper: RTL and testbench
=====================================

Name: exhaustive_sweeper

Overview:
- Parametrised, clocked successor to the team's fixed 3-input exhaustive stimulus benches.
- Walks every IN_W-bit input vector in a selectable order and holds each vector for DWELL cycles.
- Samples the DUT response against a golden expected value at the end of each dwell.
- Counts mismatches and records the first failing vector; synthesizable, so usable in-bench and on-board.

Parameters:
- IN_W, 3, stimulus width; sweep covers 2^IN_W vectors (1..16).
- OUT_W, 6, DUT response / expected width.
- DWELL, 4, cycles each vector is held (>=1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a sweep; accepted only when busy=0.
- mode  in  2  order: 00 ascending, 01 descending, 10 Gray, 11 reserved (treated as ascending); latched on accept.
- stim  out  IN_W  vector driven to DUT.
- resp  in  OUT_W  DUT output.
- expected  in  OUT_W  golden-model output for current stim.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until next accepted start.
- sample_valid  out  1  one-cycle pulse per sampled vector.
- sample_vec  out  IN_W  stim value of the vector just sampled.
- mismatch  out  1  qualifies sample_valid; resp != expected.
- err_count  out  IN_W+1  total mismatches this sweep.
- fail_seen  out  1  at least one mismatch this sweep.
- first_fail_vec  out  IN_W  stim of first mismatch; valid when fail_seen=1.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all outputs 0, including stim. Reset mid-sweep aborts with no completion pulse.
- FSM states: IDLE, DRIVE, DONE.
  - IDLE/DONE + start: latch mode; idx=0; dwell counter=0; clear err_count, fail_seen, first_fail_vec, done; go to DRIVE.
  - DRIVE: busy=1; stim=map(idx) as a registered output.
- Index mapping:
  - ascending: map(i)=i
  - descending: map(i)=~i (IN_W bits)
  - Gray: map(i)=i^(i>>1)
- Timing:
  - stim=map(0) appears in the cycle after start is accepted.
  - Each vector is stable for exactly DWELL cycles.
  - Sample edge = the clock edge ending the vector's DWELL-th cycle. At that edge, compare resp vs expected.
  - The following cycle shows sample_valid=1, sample_vec=map(idx), mismatch, and updated err_count/fail_seen/first_fail_vec.
  - On a mismatch, first_fail_vec is written only when fail_seen was 0.
- Advance and completion:
  - After the sample edge, if idx != 2^IN_W-1: idx+1, dwell counter=0, stay in DRIVE. The next stim appears in the same cycle as that sample's sample_valid.
  - Else go to DONE: busy=0, done=1 in the same cycle as the final sample_valid.
  - stim holds its last value in DONE.
- Start to done = 2^IN_W*DWELL cycles, measured from the first stim cycle to the done assertion cycle inclusive of the final dwell, plus 1.
- err_count is IN_W+1 bits wide, so the maximum 2^IN_W cannot overflow; no saturation is needed.
- start while busy=1 is ignored. start in the same cycle as rst_n=0: reset wins.
- mode changes mid-sweep have no effect.
- DWELL=1: a new vector every cycle; sample_valid is high continuously for 2^IN_W cycles.

Test Plan:
- IN_W=3, DWELL=4, mode=00, resp tied to expected -> stim 0..7, each for 4 cycles; 8 sample_valid pulses; mismatch never set; err_count=0; fail_seen=0; done=1 and busy=0 on cycle 33 after the start edge.
- Same setup with resp forced to differ when stim==5 -> exactly one mismatch pulse with sample_vec=5; err_count=1; first_fail_vec=5; fail_seen=1.
- mode=10 -> stim order 0,1,3,2,6,7,5,4. mode=01 -> order 7,6,5,4,3,2,1,0. mode=11 -> ascending.
- resp=~expected always -> 8 mismatches; err_count=4'b1000; first_fail_vec=map(0).
- Pulse start during the sweep and toggle mode mid-sweep -> sequence and timing unchanged. A new start in DONE clears done, err_count and fail_seen, then restarts at map(0).
- Assert rst_n=0 asynchronously at stim==3 -> all outputs 0 immediately with no done. DWELL=1 -> 8 consecutive sample_valid cycles, done after 8 cycles.

Source files
------------

// File: rtl/exhaustive_sweeper_if.sv
// Stimulus/response bundle between the exhaustive sweeper and the environment
// that owns the DUT and its golden model.
interface exhaustive_sweeper_if #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 6
);
  logic              start;
  logic [1:0]        mode;
  logic [IN_W-1:0]   stim;
  logic [OUT_W-1:0]  resp;
  logic [OUT_W-1:0]  expected;
  logic              busy;
  logic              done;
  logic              sample_valid;
  logic [IN_W-1:0]   sample_vec;
  logic              mismatch;
  logic [IN_W:0]     err_count;
  logic              fail_seen;
  logic [IN_W-1:0]   first_fail_vec;

  modport master (
    input  start, mode, resp, expected,
    output stim, busy, done, sample_valid, sample_vec, mismatch,
           err_count, fail_seen, first_fail_vec
  );

  modport slave (
    output start, mode, resp, expected,
    input  stim, busy, done, sample_valid, sample_vec, mismatch,
           err_count, fail_seen, first_fail_vec
  );
endinterface

// File: rtl/exhaustive_sweeper.sv
// Walks all 2^IN_W stimulus vectors in a selectable order, holds each for DWELL
// cycles and scores the DUT response against the golden value at the end of each dwell.
module exhaustive_sweeper #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 6,
  parameter int unsigned DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  exhaustive_sweeper_if.master bus
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned ERR_W = IN_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [IN_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IN_W-1:0]   stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sv_q, sv_d;
  logic [IN_W-1:0]   svec_q, svec_d;
  logic              mis_q, mis_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fail_q, fail_d;
  logic [IN_W-1:0]   ffv_q, ffv_d;

  logic [OUT_W-1:0]  diff_c;
  logic              last_dwell_c;
  logic              last_idx_c;

  // Sweep order: ascending, descending (bitwise complement) or reflected Gray.
  function automatic logic [IN_W-1:0] map_idx(input logic [IN_W-1:0] i, input logic [1:0] m);
    case (m)
      2'b01:   map_idx = ~i;
      2'b10:   map_idx = i ^ (i >> 1);
      default: map_idx = i;
    endcase
  endfunction

  assign diff_c       = bus.resp ^ bus.expected;
  assign last_dwell_c = (cnt_q == CNT_W'(DWELL - 1));
  assign last_idx_c   = (idx_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sv_q    <= 1'b0;
      svec_q  <= '0;
      mis_q   <= 1'b0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      ffv_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sv_q    <= sv_d;
      svec_q  <= svec_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      ffv_q   <= ffv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_DRIVE;
      S_DRIVE:        if (last_dwell_c && last_idx_c) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath next values; the final sample and the DONE flag land in the same cycle.
  always_comb begin
    mode_d = mode_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    stim_d = stim_q;
    sv_d   = 1'b0;
    svec_d = svec_q;
    mis_d  = 1'b0;
    err_d  = err_q;
    fail_d = fail_q;
    ffv_d  = ffv_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          mode_d = bus.mode;
          idx_d  = '0;
          cnt_d  = '0;
          stim_d = map_idx('0, bus.mode);
          err_d  = '0;
          fail_d = 1'b0;
          ffv_d  = '0;
        end
      end
      S_DRIVE: begin
        if (last_dwell_c) begin
          sv_d   = 1'b1;
          svec_d = stim_q;
          mis_d  = |diff_c;
          if (|diff_c) begin
            err_d  = err_q + ERR_W'(1);
            fail_d = 1'b1;
            if (!fail_q) ffv_d = stim_q;
          end
          if (!last_idx_c) begin
            idx_d  = idx_q + 1'b1;
            cnt_d  = '0;
            stim_d = map_idx(idx_q + 1'b1, mode_q);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == S_DRIVE);
    done_d = (state_d == S_DONE);
  end

  assign bus.stim           = stim_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.sample_valid   = sv_q;
  assign bus.sample_vec     = svec_q;
  assign bus.mismatch       = mis_q;
  assign bus.err_count      = err_q;
  assign bus.fail_seen      = fail_q;
  assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_exhaustive_sweeper.sv
// Randomized bench for exhaustive_sweeper: two instances (DWELL=4 and DWELL=1) scored
// against a cycle-level reference built from the ordering and timing rules.
module tb_exhaustive_sweeper;
  localparam int unsigned IN_W  = 3;
  localparam int unsigned OUT_W = 6;
  localparam int          N     = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start_r, sel;
  logic [1:0]       mode_r;
  logic [7:0]       fault_set;
  logic [OUT_W-1:0] gold [0:7];
  int n_checks = 0;
  int n_fail   = 0;

  exhaustive_sweeper_if #(.IN_W(IN_W), .OUT_W(OUT_W)) b4 ();
  exhaustive_sweeper_if #(.IN_W(IN_W), .OUT_W(OUT_W)) b1 ();

  exhaustive_sweeper #(.IN_W(IN_W), .OUT_W(OUT_W), .DWELL(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  exhaustive_sweeper #(.IN_W(IN_W), .OUT_W(OUT_W), .DWELL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  assign b4.start    = start_r & ~sel;
  assign b1.start    = start_r & sel;
  assign b4.mode     = mode_r;
  assign b1.mode     = mode_r;
  assign b4.expected = gold[b4.stim];
  assign b1.expected = gold[b1.stim];
  assign b4.resp     = fault_set[b4.stim] ? ~gold[b4.stim] : gold[b4.stim];
  assign b1.resp     = fault_set[b1.stim] ? ~gold[b1.stim] : gold[b1.stim];

  // Observed trace of the selected instance, indexed by cycle after the accepting edge.
  logic [2:0] ob_stim [0:63];
  logic [2:0] ob_vec  [0:63];
  logic [2:0] ob_ffv  [0:63];
  logic [3:0] ob_err  [0:63];
  logic       ob_sv   [0:63];
  logic       ob_mis  [0:63];
  logic       ob_busy [0:63];
  logic       ob_done [0:63];
  logic       ob_fail [0:63];

  function automatic logic [2:0] ref_map(input int k, input logic [1:0] m);
    case (m)
      2'b01:   return 3'(N - 1 - k);
      2'b10:   return 3'(k ^ (k >> 1));
      default: return 3'(k);
    endcase
  endfunction

  task automatic run_sweep(input logic [1:0] m, input int dwell, input bit noisy);
    int last;
    last = N * dwell + 1;
    @(negedge clk); start_r = 1'b1; mode_r = m;
    @(negedge clk); start_r = 1'b0;
    for (int c = 1; c <= last; c++) begin
      ob_stim[c] = sel ? b1.stim           : b4.stim;
      ob_vec[c]  = sel ? b1.sample_vec     : b4.sample_vec;
      ob_ffv[c]  = sel ? b1.first_fail_vec : b4.first_fail_vec;
      ob_err[c]  = sel ? b1.err_count      : b4.err_count;
      ob_sv[c]   = sel ? b1.sample_valid   : b4.sample_valid;
      ob_mis[c]  = sel ? b1.mismatch       : b4.mismatch;
      ob_busy[c] = sel ? b1.busy           : b4.busy;
      ob_done[c] = sel ? b1.done           : b4.done;
      ob_fail[c] = sel ? b1.fail_seen      : b4.fail_seen;
      if (noisy) begin
        start_r = (c >= 2 && c <= 4);
        mode_r  = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
    end
    start_r = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] agg;
    agg = {b4.stim, b4.sample_vec, b4.first_fail_vec, b4.err_count, b4.busy, b4.done,
           b4.sample_valid, b4.mismatch, b4.fail_seen, 13'd0};
    n_checks++; if (agg !== 32'd0) begin n_fail++; $display("FAIL reset_dwell4 got=%h exp=0", agg); end
    agg = {b1.stim, b1.sample_vec, b1.first_fail_vec, b1.err_count, b1.busy, b1.done,
           b1.sample_valid, b1.mismatch, b1.fail_seen, 13'd0};
    n_checks++; if (agg !== 32'd0) begin n_fail++; $display("FAIL reset_dwell1 got=%h exp=0", agg); end
  endtask

  task automatic test_sweeps(input bit s, input int dwell, input int nrand);
    logic [1:0] modes  [0:6] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
    logic [7:0] faults [0:6] = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    int last;
    last = N * dwell + 1;
    sel = s;
    for (int sc = 0; sc < 7 + nrand; sc++) begin
      logic [1:0] m;
      bit noisy, seen;
      int err;
      logic [2:0] ff;
      if (sc < 7) begin
        m = modes[sc];
        fault_set = (sc >= 2 && sc <= 4) ? 8'($urandom) : faults[sc];
        noisy = (sc == 6);
      end else begin
        m = 2'($urandom_range(0, 3));
        fault_set = 8'($urandom);
        noisy = 1'($urandom_range(0, 1));
      end
      run_sweep(m, dwell, noisy);
      seen = 1'b0; err = 0; ff = 3'd0;
      for (int c = 1; c <= last; c++) begin
        int k;
        bit esv;
        k = (c - 1) / dwell;
        if (k > N - 1) k = N - 1;
        esv = (c > 1) && ((c - 1) % dwell == 0);
        if (esv) begin
          logic [2:0] v;
          bit emis;
          v = ref_map((c - 1) / dwell - 1, m);
          emis = fault_set[v];
          if (emis) begin
            if (!seen) ff = v;
            seen = 1'b1;
            err++;
          end
          n_checks++; if (ob_vec[c] !== v) begin n_fail++; $display("FAIL sample_vec d=%0d m=%0d c=%0d got=%0d exp=%0d", dwell, m, c, ob_vec[c], v); end
          n_checks++; if (ob_mis[c] !== emis) begin n_fail++; $display("FAIL mismatch d=%0d m=%0d c=%0d got=%0b exp=%0b", dwell, m, c, ob_mis[c], emis); end
        end
        n_checks++; if (ob_stim[c] !== ref_map(k, m)) begin n_fail++; $display("FAIL stim d=%0d m=%0d c=%0d got=%0d exp=%0d", dwell, m, c, ob_stim[c], ref_map(k, m)); end
        n_checks++; if (ob_sv[c] !== esv) begin n_fail++; $display("FAIL sample_valid d=%0d m=%0d c=%0d got=%0b exp=%0b", dwell, m, c, ob_sv[c], esv); end
        n_checks++; if (ob_busy[c] !== (c < last)) begin n_fail++; $display("FAIL busy d=%0d m=%0d c=%0d got=%0b exp=%0b", dwell, m, c, ob_busy[c], c < last); end
        n_checks++; if (ob_done[c] !== (c == last)) begin n_fail++; $display("FAIL done d=%0d m=%0d c=%0d got=%0b exp=%0b", dwell, m, c, ob_done[c], c == last); end
        n_checks++; if (ob_err[c] !== 4'(err)) begin n_fail++; $display("FAIL err_count d=%0d m=%0d c=%0d got=%0d exp=%0d", dwell, m, c, ob_err[c], err); end
        n_checks++; if (ob_fail[c] !== seen) begin n_fail++; $display("FAIL fail_seen d=%0d m=%0d c=%0d got=%0b exp=%0b", dwell, m, c, ob_fail[c], seen); end
        if (seen) begin
          n_checks++; if (ob_ffv[c] !== ff) begin n_fail++; $display("FAIL first_fail_vec d=%0d m=%0d c=%0d got=%0d exp=%0d", dwell, m, c, ob_ffv[c], ff); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found, bad;
    logic [31:0] agg;
    sel = 1'b0;
    fault_set = 8'hFF;
    @(negedge clk); start_r = 1'b1; mode_r = 2'b00;
    @(negedge clk); start_r = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (b4.busy && b4.stim == 3'd3) found = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL reach_stim3 got=%0d exp=3", b4.stim); end
    #2 rst_n = 1'b0;
    #1;
    agg = {b4.stim, b4.sample_vec, b4.first_fail_vec, b4.err_count, b4.busy, b4.done,
           b4.sample_valid, b4.mismatch, b4.fail_seen, 13'd0};
    n_checks++; if (agg !== 32'd0) begin n_fail++; $display("FAIL async_reset_mid got=%h exp=0", agg); end
    start_r = 1'b1;
    repeat (2) @(negedge clk);
    start_r = 1'b0;
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (b4.busy !== 1'b0 || b4.done !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL post_reset_idle got=busy/done seen exp=idle"); end
  endtask

  initial begin
    start_r = 1'b0; sel = 1'b0; mode_r = 2'b00; fault_set = 8'h00;
    for (int i = 0; i < 8; i++) gold[i] = 6'($urandom);
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_sweeps(1'b0, 4, 3);
    test_sweeps(1'b1, 1, 3);
    test_reset_mid();
    test_sweeps(1'b0, 4, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
